fifo_victim_ctrl: RTL and testbench

//   Replacement controller for one cache set of NUM_WAYS ways.
//   - Tracks per-way valid bit and age counter; answers allocation requests with a victim way.
//   - Victim rule: an invalid way if one exists, else the oldest way (FIFO order).
//   - Holds the victim stable until the fill engine reports completion. Sits between miss handler and data/tag arrays.

---
 rtl/fifo_victim_ctrl_pkg.sv | 24 ++
 rtl/fifo_victim_ctrl_if.sv | 37 +++
 rtl/fifo_victim_pick.sv | 58 +++++
 rtl/fifo_victim_ctrl.sv | 121 ++++++++++++
 tb/tb_fifo_victim_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_victim_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared definitions for the set replacement controller:
//   ST_IDLE / ST_BUSY : allocation FSM state encoding
//   clog2()           : way-index width helper (minimum result 1)
// ---------------------------------------------------------------------------
package fifo_ctrl_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/fifo_victim_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_victim_ctrl_if
// Miss-handler <-> replacement-controller handshake bundle.
//   alloc_req, fill_done, flush, hit_valid, hit_way  : miss handler -> ctrl
//   alloc_gnt, victim_way, victim_was_valid,
//   busy, all_valid                                  : ctrl -> miss handler
// Modports: master = miss handler side, slave = controller side.
// ---------------------------------------------------------------------------
interface fifo_victim_ctrl_if
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_WAYS = 4
);
   localparam int WAY_W = clog2(NUM_WAYS);

   logic             alloc_req;
   logic             fill_done;
   logic             flush;
   logic             hit_valid;
   logic [WAY_W-1:0] hit_way;
   logic             alloc_gnt;
   logic [WAY_W-1:0] victim_way;
   logic             victim_was_valid;
   logic             busy;
   logic             all_valid;

   modport master (
      output alloc_req, fill_done, flush, hit_valid, hit_way,
      input  alloc_gnt, victim_way, victim_was_valid, busy, all_valid
   );

   modport slave (
      input  alloc_req, fill_done, flush, hit_valid, hit_way,
      output alloc_gnt, victim_way, victim_was_valid, busy, all_valid
   );

endinterface

// File: rtl/fifo_victim_pick.sv
// ---------------------------------------------------------------------------
// fifo_victim_pick
// Combinational victim selection over one set.
//   valid[NUM_WAYS]  in  : per-way valid bits
//   age[NUM_WAYS]    in  : per-way age counters
//   way              out : lowest-index invalid way, else oldest way
//                          (ties resolved to the lowest index)
//   way_valid        out : selected way currently holds valid data
// ---------------------------------------------------------------------------
module fifo_victim_pick
   import fifo_ctrl_pkg::*;
#(
   parameter  int NUM_WAYS = 4,
   parameter  int AGE_W    = 8,
   localparam int WAY_W    = clog2(NUM_WAYS)
) (
   input  logic [NUM_WAYS-1:0] valid,
   input  logic [AGE_W-1:0]    age [NUM_WAYS],
   output logic [WAY_W-1:0]    way,
   output logic                way_valid
);

   logic             inv_found;
   logic [WAY_W-1:0] inv_idx;
   logic [WAY_W-1:0] max_idx;
   logic [AGE_W-1:0] max_age;

   always_comb begin
      inv_found = 1'b0;
      inv_idx   = '0;
      // Scan downwards so the last hit is the lowest-index invalid way.
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            inv_found = 1'b1;
            inv_idx   = WAY_W'(i);
         end
      end

      max_idx = '0;
      max_age = age[0];
      // Strict compare keeps the lowest index on equal ages.
      for (int i = 1; i < NUM_WAYS; i++) begin
         if (age[i] > max_age) begin
            max_age = age[i];
            max_idx = WAY_W'(i);
         end
      end

      if (inv_found) begin
         way       = inv_idx;
         way_valid = 1'b0;
      end else begin
         way       = max_idx;
         way_valid = 1'b1;
      end
   end

endmodule

// File: rtl/fifo_victim_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_victim_ctrl
// Replacement controller for one cache set of NUM_WAYS ways. Keeps a valid
// bit and a saturating age counter per way, hands out a victim on request
// and holds it until the fill engine reports completion.
//   clk    in : clock, rising edge
//   rst_n  in : asynchronous active-low reset
//   bus       : fifo_victim_ctrl_if.slave
//               alloc_req/fill_done/flush/hit_valid/hit_way in,
//               alloc_gnt/victim_way/victim_was_valid/busy/all_valid out
// Build option: define LRU_TOUCH_EN to let lookup hits reset a way's age
// (LRU order); without it hit_valid/hit_way are ignored (pure FIFO order).
// ---------------------------------------------------------------------------
module fifo_victim_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int NUM_WAYS = 4,
   parameter int AGE_W    = 8
) (
   input logic               clk,
   input logic               rst_n,
   fifo_victim_ctrl_if.slave bus
);

   localparam int WAY_W = clog2(NUM_WAYS);

   function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] a);
      return (a == '1) ? a : a + AGE_W'(1);
   endfunction

   logic [0:0]          state;
   logic [NUM_WAYS-1:0] valid;
   logic [AGE_W-1:0]    age [NUM_WAYS];
   logic                gnt_r;
   logic [WAY_W-1:0]    victim_way_r;
   logic                victim_was_valid_r;
   logic                all_valid_r;

   logic [WAY_W-1:0]    pick_way;
   logic                pick_valid;
   logic                touch;

   fifo_victim_pick #(
      .NUM_WAYS (NUM_WAYS),
      .AGE_W    (AGE_W)
   ) u_pick (
      .valid     (valid),
      .age       (age),
      .way       (pick_way),
      .way_valid (pick_valid)
   );

`ifdef LRU_TOUCH_EN
   // A hit refreshes a valid way, except the victim being refilled.
   always_comb begin
      touch = 1'b0;
      if (bus.hit_valid && (int'(bus.hit_way) < NUM_WAYS)) begin
         touch = valid[bus.hit_way] &&
                 !((state == ST_BUSY) && (bus.hit_way == victim_way_r));
      end
   end
`else
   logic unused_hit;
   assign unused_hit = ^{bus.hit_valid, bus.hit_way};
   assign touch      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= ST_IDLE;
         valid              <= '0;
         for (int i = 0; i < NUM_WAYS; i++) age[i] <= '0;
         gnt_r              <= 1'b0;
         victim_way_r       <= '0;
         victim_was_valid_r <= 1'b0;
         all_valid_r        <= 1'b0;
      end else begin
         gnt_r       <= 1'b0;
         all_valid_r <= &valid;

         for (int i = 0; i < NUM_WAYS; i++) begin
            if (valid[i]) age[i] <= sat_inc(age[i]);
         end

         if (touch) age[bus.hit_way] <= '0;

         if (state == ST_IDLE) begin
            if (bus.alloc_req) begin
               victim_way_r       <= pick_way;
               victim_was_valid_r <= pick_valid;
               gnt_r              <= 1'b1;
               state              <= ST_BUSY;
            end
         end else begin
            if (bus.fill_done) begin
               valid[victim_way_r] <= 1'b1;
               age[victim_way_r]   <= '0;
               state               <= ST_IDLE;
            end
         end

         // Flush wins over everything above, including a same-edge fill.
         if (bus.flush) begin
            state              <= ST_IDLE;
            valid              <= '0;
            for (int i = 0; i < NUM_WAYS; i++) age[i] <= '0;
            gnt_r              <= 1'b0;
            victim_way_r       <= '0;
            victim_was_valid_r <= 1'b0;
            all_valid_r        <= 1'b0;
         end
      end
   end

   assign bus.alloc_gnt        = gnt_r;
   assign bus.victim_way       = victim_way_r;
   assign bus.victim_was_valid = victim_was_valid_r;
   assign bus.busy             = (state == ST_BUSY);
   assign bus.all_valid        = all_valid_r;

endmodule

// File: tb/tb_fifo_victim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_victim_ctrl
// Directed bench for fifo_victim_ctrl (NUM_WAYS=4, AGE_W=8). Expected values
// are hand-derived; honours LRU_TOUCH_EN for the touch scenario.
// ---------------------------------------------------------------------------
module tb_fifo_victim_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fifo_victim_ctrl_if #(.NUM_WAYS(4)) bus ();

   fifo_victim_ctrl #(
      .NUM_WAYS (4),
      .AGE_W    (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges; return 1 time unit after the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.alloc_req = 1'b0;
      bus.fill_done = 1'b0;
      bus.flush     = 1'b0;
      bus.hit_valid = 1'b0;
      bus.hit_way   = 2'd0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
   endtask

   // Request a victim and check the grant; leaves the controller BUSY.
   task automatic alloc_only(input string tag, input int exp_way, input int exp_wv);
      bus.alloc_req = 1'b1;
      cyc(1);
      bus.alloc_req = 1'b0;
      chk({tag, ".gnt"},  bus.alloc_gnt,        1);
      chk({tag, ".way"},  bus.victim_way,       exp_way);
      chk({tag, ".wv"},   bus.victim_was_valid, exp_wv);
      chk({tag, ".busy"}, bus.busy,             1);
   endtask

   // Request, then report fill_done three cycles after the grant edge.
   task automatic alloc_fill(input string tag, input int exp_way, input int exp_wv);
      alloc_only(tag, exp_way, exp_wv);
      cyc(1);
      chk({tag, ".gnt_off"}, bus.alloc_gnt,  0);
      chk({tag, ".hold"},    bus.victim_way, exp_way);
      cyc(1);
      bus.fill_done = 1'b1;
      cyc(1);
      bus.fill_done = 1'b0;
      chk({tag, ".idle"}, bus.busy, 0);
   endtask

   task automatic cold_fill(input string tag);
      alloc_fill({tag, ".w0"}, 0, 0);
      alloc_fill({tag, ".w1"}, 1, 0);
      alloc_fill({tag, ".w2"}, 2, 0);
      chk({tag, ".av_partial"}, bus.all_valid, 0);
      alloc_fill({tag, ".w3"}, 3, 0);
      cyc(1);
      chk({tag, ".av_full"}, bus.all_valid, 1);
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #12;
      chk("rst.gnt",  bus.alloc_gnt,        0);
      chk("rst.way",  bus.victim_way,       0);
      chk("rst.wv",   bus.victim_was_valid, 0);
      chk("rst.busy", bus.busy,             0);
      chk("rst.av",   bus.all_valid,        0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1);

      // fill_done while IDLE must not commit anything
      bus.fill_done = 1'b1;
      cyc(1);
      bus.fill_done = 1'b0;
      chk("idlefill.busy", bus.busy, 0);

      // Cold fill then FIFO eviction order
      cold_fill("cold");
      alloc_fill("evict0", 0, 1);
      alloc_fill("evict1", 1, 1);

      // Saturation: way0 refilled (young), then all ages pin at 255 -> tie -> way0
      do_reset();
      cold_fill("satfill");
      alloc_fill("sat.ev0", 0, 1);
      cyc(300);
      alloc_fill("sat", 0, 1);

      // Flush together with fill_done while BUSY on way1
      do_reset();
      cold_fill("flfill");
      alloc_fill("fl.ev0", 0, 1);
      alloc_only("fl.ev1", 1, 1);
      cyc(1);
      bus.flush     = 1'b1;
      bus.fill_done = 1'b1;
      cyc(1);
      clear_inputs();
      chk("flush.busy", bus.busy,             0);
      chk("flush.av",   bus.all_valid,        0);
      chk("flush.way",  bus.victim_way,       0);
      chk("flush.wv",   bus.victim_was_valid, 0);
      chk("flush.gnt",  bus.alloc_gnt,        0);
      alloc_fill("flush.next", 0, 0);
      // Flush also overrides an alloc_req in IDLE
      bus.flush     = 1'b1;
      bus.alloc_req = 1'b1;
      cyc(1);
      clear_inputs();
      chk("flalloc.gnt",  bus.alloc_gnt, 0);
      chk("flalloc.busy", bus.busy,      0);
      alloc_fill("flalloc.next", 0, 0);

      // LRU touch of way0 after a cold fill
      do_reset();
      cold_fill("lrufill");
      bus.hit_valid = 1'b1;
      bus.hit_way   = 2'd0;
      cyc(1);
      bus.hit_valid = 1'b0;
`ifdef LRU_TOUCH_EN
      alloc_only("lru", 1, 1);
`else
      alloc_only("lru", 0, 1);
`endif

      // Asynchronous reset while BUSY, during the grant cycle
      do_reset();
      cold_fill("rstfill");
      alloc_fill("rb.ev0", 0, 1);
      alloc_only("rb.ev1", 1, 1);
      rst_n = 1'b0;
      #2;
      chk("rb.gnt",  bus.alloc_gnt,        0);
      chk("rb.way",  bus.victim_way,       0);
      chk("rb.wv",   bus.victim_was_valid, 0);
      chk("rb.busy", bus.busy,             0);
      chk("rb.av",   bus.all_valid,        0);
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      alloc_fill("rb.next", 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
